axil_cmd_master: RTL and testbench

AXI4-Lite master (initiator) that converts a simple one-command-at-a-time request/response interface into single AXI4-Lite write or read transactions. It is the driving end of the sensor-emulator control register bus: an on-chip sequencer (or testbench) uses it to reset and load the FIFOs, start and hard-stop playback, and poll the status registers. One outstanding transaction at a time; a per-transaction timeout detects a hung slave.

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_cmd_master.sv | 219 +++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the control-register bus.
// Used by the command master and the register-file slaves.
package axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [2:0] AXI_PROT  = 3'b000;
  localparam logic [3:0] AXI_WSTRB = 4'hF;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: one command in, one single-beat transaction out,
// with a per-transaction timeout against hung slaves.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        idle,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  output logic [2:0]  M_AXI_AWPROT,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rvld_q, rvld_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;
  logic          tout_q, tout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic busy;
  logic done;
  logic expire;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rvld_q    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rvld_q    <= rvld_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tout_q    <= tout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rvld_d    = rvld_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tout_d    = tout_q;
    cnt_d     = cnt_q;

    busy = (state_q == S_WADDR) ||
           (state_q == S_WRESP) ||
           (state_q == S_RADDR) ||
           (state_q == S_RDATA);
    done = ((state_q == S_WRESP) && M_AXI_BVALID) ||
           ((state_q == S_RDATA) && M_AXI_RVALID);
    // A completing beat on the final allowed cycle beats the timeout.
    expire = TO_EN && busy && (cnt_q == LAST) && !done;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (busy && TO_EN) begin
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          rvld_d   = 1'b1;
          resp_d   = M_AXI_BRESP;
          rdata_d  = '0;
          tout_d   = 1'b0;
          state_d  = S_RSP;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          rvld_d   = 1'b1;
          resp_d   = M_AXI_RRESP;
          rdata_d  = M_AXI_RDATA;
          tout_d   = 1'b0;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rvld_d    = 1'b1;
      resp_d    = RESP_SLVERR;
      rdata_d   = '0;
      tout_d    = 1'b1;
      state_d   = S_RSP;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign idle          = (state_q == S_IDLE) && !cmd_valid;
  assign rsp_valid     = rvld_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = tout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = AXI_WSTRB;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: per-transaction timeline model
// compared against the DUT on every cycle.
module tb_axil_cmd_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        idle;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [2:0]  awprot;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  axil_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .idle(idle),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWPROT(awprot), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARPROT(arprot), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int errors = 0;
  int cur_c = -1;
  logic chk_en = 1'b0;

  logic e_cmd_ready, e_idle, e_awvalid, e_wvalid;
  logic e_bready, e_arvalid, e_rready, e_rsp_valid;
  logic e_fchk, e_tout;
  logic [1:0]  e_resp;
  logic [31:0] e_rdata, e_addr, e_wdata;

  int obs_fr, obs_fb, obs_law, obs_lw, obs_lar;
  logic [31:0] obs_rd;
  logic [1:0]  obs_resp;
  logic        obs_to;

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d actual %h required %h",
               nm, cur_c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cmd_ready", cmd_ready, e_cmd_ready);
      cmp("idle", idle, e_idle);
      cmp("awvalid", awvalid, e_awvalid);
      cmp("wvalid", wvalid, e_wvalid);
      cmp("bready", bready, e_bready);
      cmp("arvalid", arvalid, e_arvalid);
      cmp("rready", rready, e_rready);
      cmp("rsp_valid", rsp_valid, e_rsp_valid);
      cmp("awprot", awprot, 0);
      cmp("arprot", arprot, 0);
      cmp("wstrb", wstrb, 32'hF);
      if (e_awvalid) cmp("awaddr", awaddr, e_addr);
      if (e_wvalid) cmp("wdata", wdata, e_wdata);
      if (e_arvalid) cmp("araddr", araddr, e_addr);
      if (e_fchk) begin
        cmp("rsp_timeout", rsp_timeout, e_tout);
        cmp("rsp_resp", rsp_resp, e_resp);
        cmp("rsp_rdata", rsp_rdata, e_rdata);
      end
      if (bready && obs_fb < 0) obs_fb = cur_c;
      if (awvalid) obs_law = cur_c;
      if (wvalid) obs_lw = cur_c;
      if (arvalid) obs_lar = cur_c;
      if (rsp_valid && obs_fr < 0) begin
        obs_fr = cur_c;
        obs_rd = rsp_rdata;
        obs_resp = rsp_resp;
        obs_to = rsp_timeout;
      end
    end
  end

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_rst_exp();
    e_cmd_ready = 1'b1;
    e_idle = 1'b1;
    e_awvalid = 1'b0;
    e_wvalid = 1'b0;
    e_bready = 1'b0;
    e_arvalid = 1'b0;
    e_rready = 1'b0;
    e_rsp_valid = 1'b0;
    e_fchk = 1'b1;
    e_tout = 1'b0;
    e_resp = 2'd0;
    e_rdata = '0;
  endtask

  task automatic quiet_inputs();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
  endtask

  // d1: AW/AR accept delay, d2: W accept delay, d3: B/R delay
  // after the address phase, rdly: rsp_ready delay.
  task automatic run_txn(bit wr, logic [31:0] addr,
                         logic [31:0] wd, int d1, int d2,
                         int d3, logic [1:0] resp,
                         logic [31:0] rd, int rdly,
                         int rst_at);
    int ha, hw, a, hl, e, r;
    bit to;
    ha = 1 + d1;
    hw = wr ? 1 + d2 : 0;
    a = (hw > ha) ? hw : ha;
    hl = a + 1 + d3;
    to = (hl > T);
    e = to ? T : hl;
    r = e + 1 + rdly;
    obs_fr = -1; obs_fb = -1; obs_law = -1;
    obs_lw = -1; obs_lar = -1;
    for (int c = 0; c <= r + 1; c++) begin
      @(posedge clk);
      #1;
      cur_c = c;
      if (rst_at > 0 && c >= rst_at) begin
        quiet_inputs();
        resetn = (c >= rst_at + 2);
        chk_en = (c > rst_at);
        set_rst_exp();
        if (c == rst_at + 2) break;
        continue;
      end
      cmd_valid = (c == 0) ||
                  (c <= r && $urandom_range(0, 1) == 1);
      cmd_write = (c == 0) ? wr : 1'($urandom);
      cmd_addr = (c == 0) ? addr : $urandom;
      cmd_wdata = (c == 0) ? wd : $urandom;
      awready = wr && c == ha && ha <= T;
      wready = wr && c == hw && hw <= T;
      bvalid = wr && c == hl;
      bresp = (c == hl) ? resp : 2'($urandom);
      arready = !wr && c == ha && ha <= T;
      rvalid = !wr && c == hl;
      rresp = (c == hl) ? resp : 2'($urandom);
      rdata = (c == hl) ? rd : $urandom;
      rsp_ready = (c == r) ||
                  (c <= e && $urandom_range(0, 1) == 1);
      e_cmd_ready = (c == 0) || (c == r + 1);
      e_idle = (c == r + 1);
      e_awvalid = wr && c >= 1 && c <= imin(ha, T);
      e_wvalid = wr && c >= 1 && c <= imin(hw, T);
      e_bready = wr && c >= a + 1 && c <= imin(hl, T);
      e_arvalid = !wr && c >= 1 && c <= imin(ha, T);
      e_rready = !wr && c >= a + 1 && c <= imin(hl, T);
      e_rsp_valid = (c >= e + 1) && (c <= r);
      e_fchk = e_rsp_valid;
      e_tout = to;
      e_resp = to ? 2'd2 : resp;
      e_rdata = (to || wr) ? 32'd0 : rd;
      e_addr = addr;
      e_wdata = wd;
      chk_en = 1'b1;
    end
  endtask

  initial begin
    quiet_inputs();
    repeat (3) @(posedge clk);
    #1;
    set_rst_exp();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    run_txn(1, 32'h24, 32'h1234_5678, 0, 0, 0, 2'd0,
            32'd0, 2, 0);
    cmp("t1_rsp_cycle", obs_fr, 3);
    cmp("t1_resp", obs_resp, 0);

    run_txn(0, 32'h0, 32'h0, 0, 0, 5, 2'd0,
            32'h1, 1, 0);
    cmp("t2_rdata", obs_rd, 1);
    cmp("t2_resp", obs_resp, 0);
    cmp("t2_timeout", obs_to, 0);

    run_txn(1, 32'h10, 32'hA5A5_0F0F, 0, 3, 0, 2'd0,
            32'd0, 0, 0);
    cmp("t3_aw_last", obs_law, 1);
    cmp("t3_w_last", obs_lw, 4);
    cmp("t3_bready_first", obs_fb, 5);

    run_txn(1, 32'h7C, 32'h55, 1, 0, 2, 2'd2,
            32'd0, 0, 0);
    cmp("t4_slverr", obs_resp, 2);
    run_txn(0, 32'h40, 32'h0, 0, 0, 1, 2'd3,
            32'hDEAD_BEEF, 0, 0);
    cmp("t4_decerr", obs_resp, 3);

    run_txn(0, 32'h8, 32'h0, 30, 0, 0, 2'd0,
            32'h9, 2, 0);
    cmp("t5_ar_last", obs_lar, 16);
    cmp("t5_timeout", obs_to, 1);
    cmp("t5_resp", obs_resp, 2);
    cmp("t5_rdata", obs_rd, 0);

    run_txn(0, 32'hC, 32'h0, 5, 0, 9, 2'd0,
            32'h77, 0, 0);
    cmp("t5_edge_timeout", obs_to, 0);
    cmp("t5_edge_rdata", obs_rd, 32'h77);
    run_txn(0, 32'hC, 32'h0, 5, 0, 10, 2'd0,
            32'h77, 0, 0);
    cmp("t5_late_timeout", obs_to, 1);

    run_txn(1, 32'h30, 32'h1, 0, 0, 5, 2'd0,
            32'd0, 0, 4);
    run_txn(1, 32'h34, 32'h2, 0, 0, 0, 2'd0,
            32'd0, 6, 0);
    cmp("t6_after_rst", obs_fr, 3);

    for (int i = 0; i < 150; i++) begin
      run_txn(1'($urandom), $urandom, $urandom,
              $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), 2'($urandom),
              $urandom, $urandom_range(0, 4), 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
